// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo master and its byte FIFO.
// Holds the FSM state encoding, UART status bit positions and echo FIFO depth.
// No logic lives here.
package uart_echo_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    localparam int RX_RDY     = 0;
    localparam int TX_EMPTY   = 1;
    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_echo_fifo.sv
// Four-entry byte FIFO holding received bytes until they are echoed back.
// Latency: a pushed byte is visible on head_dat and level the next clock.
// Backpressure: push while full and pop while empty are ignored; the caller checks full/empty.
module uart_echo_fifo
    import uart_echo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       full,
    output logic       empty,
    output logic [2:0] level
);

    logic [7:0] mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       wr_en;
    logic       rd_en;

    assign full     = (count == 3'(FIFO_DEPTH));
    assign empty    = (count == 3'd0);
    assign level    = count;
    assign head_dat = mem[rd_ptr];
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;

    // Pointers are two bits wide, so they wrap 3 -> 0 on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (rd_en) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(wr_en) - 3'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_echo_master.sv
// Bus master that programs the UART control register once, then echoes every received byte back.
// Latency: each access is ACCESS_CYCLES clocks, followed by GAP_CYCLES idle clocks and one IDLE decision clock.
// Backpressure: up to 4 bytes are buffered; further bytes are dropped and flagged. UART_ECHO_IRQ_EN gates reads on i_IRQ.
module uart_echo_master
    import uart_echo_pkg::*;
#(
    parameter int         ACCESS_CYCLES = 2,
    parameter int         GAP_CYCLES    = 2,
    parameter logic [7:0] CTRL_INIT     = 8'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    output logic       o_RW,
    output logic       o_uart_data_ce,
    output logic       o_uart_control_ce,
    output logic [7:0] o_control,
    output logic [7:0] o_uart_wdata,
    input  logic [7:0] i_uart_rdata,
    input  logic [7:0] i_uart_status,
    input  logic       i_IRQ,
    output logic [2:0] o_level,
    output logic       o_overflow,
    output logic       o_busy
);

    localparam int CNT_MAX = (ACCESS_CYCLES > GAP_CYCLES) ? ACCESS_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc_last;
    logic          gap_last;
    logic          rd_go;
    logic          wr_go;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          unused_ok;

    assign acc_last = (cnt == CW'(ACCESS_CYCLES - 1));
    assign gap_last = (cnt == CW'(GAP_CYCLES - 1));

`ifdef UART_ECHO_IRQ_EN
    assign rd_go = i_enable && i_uart_status[RX_RDY] && !i_IRQ;
`else
    assign rd_go = i_enable && i_uart_status[RX_RDY];
`endif
    assign wr_go = i_enable && !fifo_empty && i_uart_status[TX_EMPTY];

    assign unused_ok = &{1'b0, i_IRQ, i_uart_status[7:2]};

    // Push and pop only on the final clock of an access, so a reset mid-access leaves no trace.
    assign fifo_push = (state == RD) && acc_last && !fifo_full;
    assign fifo_pop  = (state == WR) && acc_last;

    uart_echo_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (i_uart_rdata),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (o_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= INIT;
            cnt               <= '0;
            o_RW              <= 1'b1;
            o_uart_data_ce    <= 1'b0;
            o_uart_control_ce <= 1'b0;
            o_control         <= 8'h00;
            o_uart_wdata      <= 8'h00;
            o_overflow        <= 1'b0;
            o_busy            <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    o_busy <= 1'b1;
                    // First clock out of reset only raises the enable; counting starts after.
                    if (!o_uart_control_ce) begin
                        o_uart_control_ce <= 1'b1;
                        o_RW              <= 1'b0;
                        o_control         <= CTRL_INIT;
                        cnt               <= '0;
                    end else if (acc_last) begin
                        o_uart_control_ce <= 1'b0;
                        o_RW              <= 1'b1;
                        o_control         <= 8'h00;
                        cnt               <= '0;
                        state             <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                IDLE: begin
                    cnt <= '0;
                    if (rd_go) begin
                        o_uart_data_ce <= 1'b1;
                        o_RW           <= 1'b1;
                        o_busy         <= 1'b1;
                        state          <= RD;
                    end else if (wr_go) begin
                        o_uart_data_ce <= 1'b1;
                        o_RW           <= 1'b0;
                        o_uart_wdata   <= fifo_head;
                        o_busy         <= 1'b1;
                        state          <= WR;
                    end
                end
                RD, WR: begin
                    if (acc_last) begin
                        o_uart_data_ce <= 1'b0;
                        o_RW           <= 1'b1;
                        cnt            <= '0;
                        state          <= GAP;
                        if (state == RD && fifo_full) o_overflow <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
